// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the EX-stage hazard controller
package pipeline_pkg;

    localparam int RA_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_t;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: pipeline-side signals seen and driven by the hazard controller
interface ex_hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = RA_W_DEF
);
    logic             id_valid;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [RA_W-1:0]  ex_dst;
    logic             mem_reg_write;
    logic [RA_W-1:0]  mem_dst;
    logic             ex_branch;
    logic             ex_zero;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             pc_src_branch;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_write, ex_dst,
               mem_reg_write, mem_dst, ex_branch, ex_zero,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_src_branch,
               fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_write, ex_dst,
               mem_reg_write, mem_dst, ex_branch, ex_zero,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_src_branch,
               fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_select.sv
// fwd_select: forwarding source for one ID operand, EX writer wins over MEM writer
module fwd_select
    import pipeline_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] operand_i,
    input  logic            ex_reg_write_i,
    input  logic [RA_W-1:0] ex_dst_i,
    input  logic            mem_reg_write_i,
    input  logic [RA_W-1:0] mem_dst_i,
    output logic [1:0]      sel_o
);

    // register 0 is hardwired, so a write to it never forwards
    always_comb begin
        sel_o = (ex_reg_write_i && ex_dst_i != '0 && ex_dst_i == operand_i)    ? FWD_MEM :
                (mem_reg_write_i && mem_dst_i != '0 && mem_dst_i == operand_i) ? FWD_WB  :
                                                                                 FWD_RF;
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: load-use stall, taken-branch flush and forwarding-select control
module ex_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = RA_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    ex_hazard_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0]       sel_a, sel_b;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu, taken_eff, lu_eff;
    logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_src_branch;

    fwd_select #(.RA_W(RA_W)) u_fwd_rs (
        .operand_i      (bus.id_rs),
        .ex_reg_write_i (bus.ex_reg_write),
        .ex_dst_i       (bus.ex_dst),
        .mem_reg_write_i(bus.mem_reg_write),
        .mem_dst_i      (bus.mem_dst),
        .sel_o          (sel_a)
    );

    fwd_select #(.RA_W(RA_W)) u_fwd_rt (
        .operand_i      (bus.id_rt),
        .ex_reg_write_i (bus.ex_reg_write),
        .ex_dst_i       (bus.ex_dst),
        .mem_reg_write_i(bus.mem_reg_write),
        .mem_dst_i      (bus.mem_dst),
        .sel_o          (sel_b)
    );

    // hazard qualification: FLUSH means EX holds a bubble (no branch), any non-RUN state masks load-use
    always_comb begin
        lu = bus.id_valid && bus.ex_mem_read && bus.ex_dst != '0 &&
             (bus.ex_dst == bus.id_rs || (bus.id_uses_rt && bus.ex_dst == bus.id_rt));
        taken_eff = bus.ex_branch && bus.ex_zero && state_q != ST_FLUSH;
        lu_eff    = lu && state_q == ST_RUN;
    end

    // state register; reset abandons any STALL/FLUSH in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // next state: branch beats load-use, both STALL and FLUSH last one cycle
    always_comb begin
        state_d = taken_eff ? ST_FLUSH : lu_eff ? ST_STALL : ST_RUN;
    end

    // pipeline control outputs, all quiet while reset is held
    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        pc_src_branch = 1'b0;
        if (rst_n) begin
            if (taken_eff) begin
                pc_write      = 1'b1;
                if_id_write   = 1'b1;
                id_ex_bubble  = 1'b1;
                if_id_flush   = 1'b1;
                pc_src_branch = 1'b1;
            end else if (lu_eff) begin
                id_ex_bubble  = 1'b1;
            end else begin
                pc_write      = 1'b1;
                if_id_write   = 1'b1;
            end
        end
    end

    // forwarding selects: cleared with a bubble, held while IF/ID is frozen
    always_comb begin
        fwd_a_d = id_ex_bubble ? FWD_RF : if_id_write ? sel_a : fwd_a_q;
        fwd_b_d = id_ex_bubble ? FWD_RF : if_id_write ? sel_b : fwd_b_q;
    end

    // saturating event counters: RUN->STALL edges and every entry into FLUSH
    always_comb begin
        stall_cnt_d = (state_q == ST_RUN && state_d == ST_STALL && !(&stall_cnt_q)) ?
                      stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (state_d == ST_FLUSH && !(&flush_cnt_q)) ?
                      flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // forwarding and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.if_id_write   = if_id_write;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.pc_src_branch = pc_src_branch;
    assign bus.fwd_a         = fwd_a_q;
    assign bus.fwd_b         = fwd_b_q;
    assign bus.state         = state_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed scoreboard bench for the hazard controller
module tb_ex_hazard_ctrl;

    localparam int CW = 4;
    localparam int RW = 5;

    localparam int K_PCW = 0, K_IFW = 1, K_BUB = 2, K_FLU = 3, K_PCS = 4;
    localparam int K_FA = 5, K_FB = 6, K_ST = 7, K_SC = 8, K_FC = 9;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    ex_hazard_ctrl_if #(.CNT_W(CW), .RA_W(RW)) bus ();

    ex_hazard_ctrl #(.CNT_W(CW), .RA_W(RW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic string kname(int k);
        case (k)
            K_PCW:   return "pc_write";
            K_IFW:   return "if_id_write";
            K_BUB:   return "id_ex_bubble";
            K_FLU:   return "if_id_flush";
            K_PCS:   return "pc_src_branch";
            K_FA:    return "fwd_a";
            K_FB:    return "fwd_b";
            K_ST:    return "state";
            K_SC:    return "stall_cnt";
            default: return "flush_cnt";
        endcase
    endfunction

    function automatic logic [31:0] obs(int k);
        case (k)
            K_PCW:   return 32'(bus.pc_write);
            K_IFW:   return 32'(bus.if_id_write);
            K_BUB:   return 32'(bus.id_ex_bubble);
            K_FLU:   return 32'(bus.if_id_flush);
            K_PCS:   return 32'(bus.pc_src_branch);
            K_FA:    return 32'(bus.fwd_a);
            K_FB:    return 32'(bus.fwd_b);
            K_ST:    return 32'(bus.state);
            K_SC:    return 32'(bus.stall_cnt);
            default: return 32'(bus.flush_cnt);
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic push_ctl(input logic pcw, input logic ifw, input logic bub,
                            input logic flu, input logic pcs);
        push(K_PCW, 32'(pcw));
        push(K_IFW, 32'(ifw));
        push(K_BUB, 32'(bub));
        push(K_FLU, 32'(flu));
        push(K_PCS, 32'(pcs));
    endtask

    task automatic drain(input string tag);
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.kind);
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s/%s observed=%0h expected=%0h", tag, kname(e.kind), o, e.val);
            end
        end
    endtask

    task automatic nop();
        bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dst = '0;
        bus.mem_reg_write = 1'b0; bus.mem_dst = '0; bus.ex_branch = 1'b0; bus.ex_zero = 1'b0;
    endtask

    task automatic load_use(input logic [RW-1:0] r);
        nop();
        bus.id_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_dst = r; bus.id_rs = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop();
        #2;
        push_ctl(0, 0, 0, 0, 0);
        push(K_ST, 0); push(K_FA, 0); push(K_FB, 0); push(K_SC, 0); push(K_FC, 0);
        drain("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        push_ctl(1, 1, 0, 0, 0); push(K_ST, 0);
        drain("idle");

        load_use(5'd3);
        #2; push_ctl(0, 0, 1, 0, 0); drain("lu_run");
        tick(); push(K_ST, 1); push(K_SC, 1); push(K_FA, 0); drain("lu_stall");
        push_ctl(1, 1, 0, 0, 0); drain("lu_masked");
        nop();
        tick(); push(K_ST, 0); push(K_SC, 1); drain("lu_back");

        load_use(5'd5);
        bus.ex_branch = 1'b1; bus.ex_zero = 1'b1;
        #2; push_ctl(1, 1, 1, 1, 1); drain("br_run");
        tick(); push(K_ST, 2); push(K_FC, 1); push(K_SC, 1); drain("br_flush");
        push_ctl(1, 1, 0, 0, 0); drain("br_ignored");
        tick(); push(K_ST, 0); push(K_FC, 1); push(K_SC, 1); drain("br_back");

        nop();
        bus.id_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd4;
        bus.mem_reg_write = 1'b1; bus.mem_dst = 5'd4; bus.id_rs = 5'd4; bus.id_rt = 5'd4;
        tick(); push(K_FA, 1); push(K_FB, 1); drain("fwd_ex");
        bus.ex_reg_write = 1'b0;
        tick(); push(K_FA, 2); push(K_FB, 2); drain("fwd_mem");
        bus.id_rt = 5'd9;
        tick(); push(K_FA, 2); push(K_FB, 0); drain("fwd_none");

        nop();
        bus.ex_reg_write = 1'b1; bus.ex_dst = '0; bus.mem_reg_write = 1'b1;
        bus.id_valid = 1'b1;
        tick(); push(K_FA, 0); push(K_FB, 0); drain("fwd_r0");
        load_use(5'd0);
        #2; push_ctl(1, 1, 0, 0, 0); drain("lu_r0");
        tick(); push(K_ST, 0); push(K_SC, 1); drain("lu_r0_state");

        load_use(5'd7);
        for (int i = 0; i < 38; i++) tick();
        push(K_ST, 0); push(K_SC, 15); push(K_FC, 1); drain("sat");
        nop();
        tick();

        load_use(5'd3);
        tick(); push(K_ST, 1); drain("rst_pre");
        #2; rst_n = 1'b0;
        #1; push_ctl(0, 0, 0, 0, 0);
        push(K_ST, 0); push(K_SC, 0); push(K_FC, 0); push(K_FA, 0); push(K_FB, 0);
        drain("rst_mid");
        nop();
        rst_n = 1'b1;
        #1; push_ctl(1, 1, 0, 0, 0); push(K_ST, 0); drain("rst_release");
        tick(); push(K_ST, 0); push(K_SC, 0); drain("rst_run");
        load_use(5'd3);
        tick(); push(K_ST, 1); push(K_SC, 1); drain("rst_resume");
        nop();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
